// File: rtl/axi_pkg.sv
// Shared AXI constants and the data-memory bridge FSM encoding.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_DONE
    } dm_state_t;

endpackage

// File: rtl/axi_wr_pair_tracker.sv
// Tracks the independent AW and W handshakes of one single-beat write and
// reports when both have completed (same-cycle completion included).
module axi_wr_pair_tracker (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic aw_hs,
    input  logic w_hs,
    output logic aw_done,
    output logic w_done,
    output logic both_done
);

    assign both_done = active && (aw_done || aw_hs) && (w_done || w_hs);

    // Flags clear whenever the write is not in its request phase, so every
    // entry into the request phase starts with both channels outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (!active || both_done) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
        end
    end

endmodule

// File: rtl/dm_axi_master.sv
// CPU data-memory port to single-beat AXI4 master bridge; drives CPU_stall.
// Define DM_AXI_ERR_EN to enable the sticky bus_err / err_addr capture.
module dm_axi_master
    import axi_pkg::*;
#(
    parameter int              ID_W      = 4,
    parameter logic [ID_W-1:0] MASTER_ID = ID_W'(1),
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              CPU_stall,
    output logic [ID_W-1:0]   ARID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [3:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [ID_W-1:0]   RID,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,
    output logic [ID_W-1:0]   AWID,
    output logic [ADDR_W-1:0] AWADDR,
    output logic [3:0]        AWLEN,
    output logic [2:0]        AWSIZE,
    output logic [1:0]        AWBURST,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [DATA_W-1:0] WDATA,
    output logic [3:0]        WSTRB,
    output logic              WLAST,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic [ID_W-1:0]   BID,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY,
    output logic              bus_err,
    output logic [ADDR_W-1:0] err_addr
);

    dm_state_t         state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;
    logic              aw_done, w_done, both_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (mem_read)       state_nxt = ST_RD_ADDR;
                else if (mem_write) state_nxt = ST_WR_REQ;
            end
            ST_RD_ADDR: if (ARREADY)   state_nxt = ST_RD_DATA;
            ST_RD_DATA: if (RVALID)    state_nxt = ST_DONE;
            ST_WR_REQ:  if (both_done) state_nxt = ST_WR_RESP;
            ST_WR_RESP: if (BVALID)    state_nxt = ST_DONE;
            // DONE never re-issues: the pipeline advances on this edge.
            ST_DONE:                   state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ARVALID   = 1'b0;
        RREADY    = 1'b0;
        AWVALID   = 1'b0;
        WVALID    = 1'b0;
        BREADY    = 1'b0;
        CPU_stall = 1'b0;
        case (state)
            ST_IDLE:    CPU_stall = mem_read || mem_write;
            ST_RD_ADDR: begin ARVALID = 1'b1; CPU_stall = 1'b1; end
            ST_RD_DATA: begin RREADY  = 1'b1; CPU_stall = 1'b1; end
            ST_WR_REQ: begin
                AWVALID   = !aw_done;
                WVALID    = !w_done;
                CPU_stall = 1'b1;
            end
            ST_WR_RESP: begin BREADY = 1'b1; CPU_stall = 1'b1; end
            default: ;
        endcase
    end

    axi_wr_pair_tracker u_wr_trk (
        .clk       (clk),
        .rst       (rst),
        .active    (state == ST_WR_REQ),
        .aw_hs     (AWVALID && AWREADY),
        .w_hs      (WVALID && WREADY),
        .aw_done   (aw_done),
        .w_done    (w_done),
        .both_done (both_done)
    );

    // Request fields are captured once in IDLE so the AXI payload stays
    // stable no matter what the MEM stage does while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            mem_rdata <= '0;
        end else begin
            if (state == ST_IDLE) begin
                if (mem_read) begin
                    addr_q <= mem_addr;
                end else if (mem_write) begin
                    addr_q  <= mem_addr;
                    wdata_q <= mem_wdata;
                    wstrb_q <= mem_wstrb;
                end
            end
            if (state == ST_RD_DATA && RVALID) mem_rdata <= RDATA;
        end
    end

    assign ARID    = MASTER_ID;
    assign ARADDR  = addr_q;
    assign ARLEN   = 4'd0;
    assign ARSIZE  = AXI_SIZE_4B;
    assign ARBURST = AXI_BURST_INCR;
    assign AWID    = MASTER_ID;
    assign AWADDR  = addr_q;
    assign AWLEN   = 4'd0;
    assign AWSIZE  = AXI_SIZE_4B;
    assign AWBURST = AXI_BURST_INCR;
    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign WLAST   = WVALID;

`ifdef DM_AXI_ERR_EN
    logic rsp_err;
    logic unused_inputs;

    assign rsp_err = (state == ST_RD_DATA && RVALID && RRESP != AXI_RESP_OKAY) ||
                     (state == ST_WR_RESP && BVALID && BRESP != AXI_RESP_OKAY);
    assign unused_inputs = ^{RID, BID, RLAST};

    // Only the first failing access is recorded; the flag is sticky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_err  <= 1'b0;
            err_addr <= '0;
        end else if (rsp_err && !bus_err) begin
            bus_err  <= 1'b1;
            err_addr <= addr_q;
        end
    end
`else
    logic unused_inputs;

    assign unused_inputs = ^{RID, BID, RLAST, RRESP, BRESP};
    assign bus_err       = 1'b0;
    assign err_addr      = '0;
`endif

endmodule

// File: tb/tb_dm_axi_master.sv
// Randomized bench for dm_axi_master: a latency-programmable AXI slave with
// memory, a reference memory model and a queue-based scoreboard monitor.
module tb_dm_axi_master;

`ifdef DM_AXI_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic [31:0] mem_rdata;
    logic        CPU_stall;
    logic [3:0]  ARID, AWID, ARLEN, AWLEN;
    logic [31:0] ARADDR, AWADDR, WDATA;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, AWBURST;
    logic        ARVALID, RREADY, AWVALID, WVALID, WLAST, BREADY;
    logic [3:0]  WSTRB;
    logic        ARREADY = 1'b0, AWREADY = 1'b0, WREADY = 1'b0;
    logic [3:0]  RID = 4'd1, BID = 4'd1;
    logic [31:0] RDATA = '0;
    logic [1:0]  RRESP = '0, BRESP = '0;
    logic        RLAST = 1'b1, RVALID = 1'b0, BVALID = 1'b0;
    logic        bus_err;
    logic [31:0] err_addr;

    always #5 clk = ~clk;

    dm_axi_master dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .CPU_stall(CPU_stall),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
        .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .bus_err(bus_err), .err_addr(err_addr)
    );

    typedef struct {
        bit          is_rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        bit          err;
        logic [31:0] err_addr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];
    logic [31:0] ref_rdata = '0;
    bit          ref_err = 1'b0;
    logic [31:0] ref_err_addr = '0;
    int          checks = 0, errors = 0;
    int          ar_lat = 0, aw_lat = 0, w_lat = 0, r_lat = 0, b_lat = 0;
    bit          hold_r = 1'b0;
    int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic bit is_err_addr(input logic [31:0] a);
        return a >= 32'h400;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic report();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // Slave: decides at the negedge which handshakes will complete, drives
    // its outputs just after the following posedge.
    initial begin
        bit s_ar_hs, s_arv, s_r_hs, s_aw_hs, s_awv, s_w_hs, s_wv, s_b_hs;
        logic [31:0] s_araddr, s_awaddr, s_wdata, rd_addr, wr_addr, wr_data;
        logic [3:0]  s_wstrb, wr_strb;
        int ar_age, aw_age, w_age, r_cnt, b_cnt;
        bit rd_pend, aw_seen, w_seen, b_pend;
        ar_age = 0; aw_age = 0; w_age = 0; r_cnt = 0; b_cnt = 0;
        rd_pend = 0; aw_seen = 0; w_seen = 0; b_pend = 0;
        rd_addr = '0; wr_addr = '0; wr_data = '0; wr_strb = '0;
        forever begin
            @(negedge clk);
            s_ar_hs = ARVALID && ARREADY; s_arv = ARVALID; s_araddr = ARADDR;
            s_r_hs  = RVALID && RREADY;
            s_aw_hs = AWVALID && AWREADY; s_awv = AWVALID; s_awaddr = AWADDR;
            s_w_hs  = WVALID && WREADY; s_wv = WVALID; s_wdata = WDATA; s_wstrb = WSTRB;
            s_b_hs  = BVALID && BREADY;
            @(posedge clk);
            #1;
            if (rst) begin
                ar_age = 0; aw_age = 0; w_age = 0;
                rd_pend = 0; aw_seen = 0; w_seen = 0; b_pend = 0;
                if (!hold_r) RVALID = 1'b0;
                BVALID = 1'b0;
            end else begin
                if (s_ar_hs) begin rd_pend = 1; rd_addr = s_araddr; r_cnt = 0; ar_age = 0; end
                else ar_age = s_arv ? ar_age + 1 : 0;
                if (!hold_r) begin
                    if (s_r_hs) begin RVALID = 1'b0; rd_pend = 0; end
                    else if (rd_pend && !RVALID) begin
                        if (r_cnt >= r_lat) begin
                            RVALID = 1'b1;
                            RDATA  = slv_mem.exists(rd_addr) ? slv_mem[rd_addr] : 32'h0;
                            RRESP  = is_err_addr(rd_addr) ? 2'b11 : 2'b00;
                        end else r_cnt++;
                    end
                end
                if (s_aw_hs) begin aw_seen = 1; wr_addr = s_awaddr; aw_age = 0; end
                else aw_age = s_awv ? aw_age + 1 : 0;
                if (s_w_hs) begin w_seen = 1; wr_data = s_wdata; wr_strb = s_wstrb; w_age = 0; end
                else w_age = s_wv ? w_age + 1 : 0;
                if (aw_seen && w_seen) begin
                    slv_mem[wr_addr] = merge(slv_mem.exists(wr_addr) ? slv_mem[wr_addr] : 32'h0,
                                             wr_data, wr_strb);
                    b_pend = 1; b_cnt = 0; aw_seen = 0; w_seen = 0;
                end
                if (s_b_hs) begin BVALID = 1'b0; b_pend = 0; end
                else if (b_pend && !BVALID) begin
                    if (b_cnt >= b_lat) begin
                        BVALID = 1'b1;
                        BRESP  = is_err_addr(wr_addr) ? 2'b10 : 2'b00;
                    end else b_cnt++;
                end
            end
            ARREADY = (ar_age >= ar_lat);
            AWREADY = (aw_age >= aw_lat);
            WREADY  = (w_age >= w_lat);
        end
    end

    // Scoreboard monitor: checks channel payloads against the head of the
    // expectation queue and retires it when the stall drops with a request up.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
            end else begin
                if (ARVALID) begin
                    chk("ar_has_txn", 32'(exp_q.size()), 32'(exp_q.size() == 0 ? 0 : exp_q.size()) + 32'(exp_q.size() == 0));
                    if (exp_q.size() != 0) begin
                        chk("araddr", ARADDR, exp_q[0].addr);
                        chk("ar_is_read", 32'(exp_q[0].is_rd), 32'd1);
                        if (ARREADY) begin
                            ar_cnt++;
                            chk("ar_fixed", 32'({ARID, ARLEN, ARSIZE, ARBURST}),
                                32'({4'd1, 4'd0, 3'b010, 2'b01}));
                        end
                    end
                end
                if (AWVALID) begin
                    chk("aw_has_txn", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        chk("awaddr", AWADDR, exp_q[0].addr);
                        chk("aw_is_write", 32'(exp_q[0].is_rd), 32'd0);
                        if (AWREADY) begin
                            aw_cnt++;
                            chk("aw_fixed", 32'({AWID, AWLEN, AWSIZE, AWBURST}),
                                32'({4'd1, 4'd0, 3'b010, 2'b01}));
                        end
                    end
                end
                if (WVALID) begin
                    chk("w_has_txn", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        chk("wdata", WDATA, exp_q[0].wdata);
                        chk("wstrb_wlast", 32'({WSTRB, WLAST}), 32'({exp_q[0].wstrb, 1'b1}));
                        if (WREADY) w_cnt++;
                    end
                end
                if (!CPU_stall && (mem_read || mem_write)) begin
                    chk("done_has_txn", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        chk("mem_rdata", mem_rdata, mon_e.rdata);
                        chk("ar_count", 32'(ar_cnt), 32'(mon_e.is_rd));
                        chk("aw_count", 32'(aw_cnt), 32'(!mon_e.is_rd));
                        chk("w_count", 32'(w_cnt), 32'(!mon_e.is_rd));
                        chk("bus_err", 32'(bus_err), 32'(mon_e.err));
                        chk("err_addr", err_addr, mon_e.err_addr);
                    end
                    ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
                end
            end
        end
    end

    // kind: 0 load, 1 store, 2 load and store together (load must win).
    task automatic do_txn(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input bit scramble, output int stalls);
        exp_t e;
        e.is_rd = (kind != 1);
        e.addr  = addr;
        e.wdata = wd;
        e.wstrb = ws;
        if (e.is_rd) ref_rdata = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
        else ref_mem[addr] = merge(ref_mem.exists(addr) ? ref_mem[addr] : 32'h0, wd, ws);
        if (ERR_EN && is_err_addr(addr) && !ref_err) begin
            ref_err = 1'b1;
            ref_err_addr = addr;
        end
        e.rdata = ref_rdata;
        e.err = ref_err;
        e.err_addr = ref_err_addr;
        exp_q.push_back(e);
        mem_read  = (kind != 1);
        mem_write = (kind != 0);
        mem_addr  = addr;
        mem_wdata = wd;
        mem_wstrb = ws;
        stalls = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!CPU_stall) break;
            stalls++;
            if (scramble && stalls > 1) begin
                mem_addr  = addr ^ 32'h200;
                mem_wdata = $urandom;
                mem_wstrb = 4'($urandom_range(0, 15));
            end
        end
        chk("txn_timeout", 32'(CPU_stall), 32'd0);
        if (CPU_stall) report();
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic set_lat(input int a, input int aw, input int w, input int r, input int b);
        ar_lat = a; aw_lat = aw; w_lat = w; r_lat = r; b_lat = b;
    endtask

    initial begin
        int st;
        int kind;
        logic [31:0] v, a;
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            ref_mem[32'h100 + 32'(4 * i)] = v;
            slv_mem[32'h100 + 32'(4 * i)] = v;
        end
        ref_mem[32'h100] = 32'hDEAD_BEEF;
        slv_mem[32'h100] = 32'hDEAD_BEEF;

        repeat (2) @(negedge clk);
        chk("rst_valids", 32'({ARVALID, RREADY, AWVALID, WVALID, BREADY}), 32'd0);
        chk("rst_stall", 32'(CPU_stall), 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        chk("rst_err", 32'(bus_err), 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        set_lat(0, 0, 0, 0, 0);
        do_txn(0, 32'h100, 32'h0, 4'h0, 1'b0, st);
        chk("load_min_stalls", 32'(st), 32'd3);
        do_txn(1, 32'h200, 32'h1234_5678, 4'b0011, 1'b0, st);
        chk("store_min_stalls", 32'(st), 32'd3);

        set_lat(0, 2, 0, 1, 1);
        do_txn(1, 32'h200, 32'h1234_5678, 4'b0011, 1'b0, st);
        set_lat(0, 0, 0, 0, 0);
        do_txn(0, 32'h200, 32'h0, 4'h0, 1'b0, st);

        set_lat(5, 0, 0, 0, 0);
        do_txn(0, 32'h100, 32'h0, 4'h0, 1'b1, st);
        chk("ar_delay_stalls", 32'(st), 32'd8);

        set_lat(1, 1, 1, 1, 1);
        do_txn(2, 32'h104, 32'hFFFF_FFFF, 4'hF, 1'b0, st);

        // Reset while the read data phase is waiting for RVALID.
        set_lat(0, 0, 0, 0, 0);
        hold_r = 1'b1;
        do_txn_start: begin
            exp_t e;
            e.is_rd = 1'b1; e.addr = 32'h180; e.wdata = '0; e.wstrb = '0;
            e.rdata = '0; e.err = 1'b0; e.err_addr = '0;
            exp_q.push_back(e);
            mem_read = 1'b1;
            mem_addr = 32'h180;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (RREADY) break;
            end
            chk("reach_rd_data", 32'(RREADY), 32'd1);
            @(posedge clk);
            #1;
            rst = 1'b1;
            mem_read = 1'b0;
            exp_q.delete();
            ref_rdata = '0;
            ref_err = 1'b0;
            ref_err_addr = '0;
            @(negedge clk);
            chk("midrst_valids", 32'({ARVALID, RREADY, AWVALID, WVALID, BREADY}), 32'd0);
            chk("midrst_stall", 32'(CPU_stall), 32'd0);
            chk("midrst_rdata", mem_rdata, 32'd0);
            @(posedge clk);
            #1;
            rst = 1'b0;
            RVALID = 1'b1;
            RDATA = 32'hCAFE_F00D;
            RRESP = 2'b11;
            repeat (3) begin
                @(negedge clk);
                chk("late_r_rready", 32'(RREADY), 32'd0);
                chk("late_r_stall", 32'(CPU_stall), 32'd0);
            end
            chk("late_r_rdata", mem_rdata, 32'd0);
            chk("late_r_err", 32'(bus_err), 32'd0);
            @(posedge clk);
            #1;
            RVALID = 1'b0;
            RRESP = 2'b00;
            hold_r = 1'b0;
        end

        do_txn(1, 32'h108, 32'hA5A5_5A5A, 4'b1100, 1'b0, st);
        do_txn(1, 32'h400, 32'h0BAD_0BAD, 4'hF, 1'b0, st);
        do_txn(0, 32'h500, 32'h0, 4'h0, 1'b0, st);
        do_txn(0, 32'h400, 32'h0, 4'h0, 1'b0, st);

        for (int n = 0; n < 60; n++) begin
            set_lat($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
            kind = $urandom_range(0, 2);
            a = 32'h100 + 32'(4 * $urandom_range(0, 63));
            do_txn(kind, a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), st);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        report();
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog expired at t=%0t", $time);
        report();
    end

endmodule
